// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, IF/ID pipeline register, branch redirect and halt.
// Optional redirect counter enabled by defining FETCH_REDIRECT_CNT_EN.
module fetch_unit #(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            stall,
  input  logic            flag_halt,
  input  logic [31:0]     Instr_in,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] ifid_pc,
  output logic [31:0]     ifid_instr,
  output logic            ifid_valid,
  output logic            halted,
  output logic [15:0]     redirect_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    HALT   = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_t          state;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] pc_inc;
  logic            unused_brpc;

  // Word-aligned target; upper BrPC bits beyond the PC width are discarded.
  assign br_target   = {BrPC[PC_W-1:2], 2'b00};
  assign pc_inc      = pc_out + PC_W'(4);
  assign unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};

  // Priority inside RUN/BUBBLE: halt over redirect over stall over normal fetch.
  // NOTE: every state and output register uses non-blocking assignments so all
  // of them update together on the edge from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      pc_out     <= '0;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        RUN, BUBBLE: begin
          if (flag_halt) begin
            state      <= HALT;
            halted     <= 1'b1;
            ifid_valid <= 1'b0;
          end else if (PcSel) begin
            state      <= BUBBLE;
            pc_out     <= br_target;
            ifid_valid <= 1'b0;
          end else if (!stall) begin
            // A bubble lasts one cycle; the target fetch then lands in IF/ID.
            state      <= RUN;
            pc_out     <= pc_inc;
            ifid_pc    <= pc_out;
            ifid_instr <= Instr_in;
            ifid_valid <= 1'b1;
          end
        end
        HALT: begin
          halted     <= 1'b1;
          ifid_valid <= 1'b0;
        end
        default: begin
          state      <= RUN;
          ifid_valid <= 1'b0;
          halted     <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_REDIRECT_CNT_EN
  logic [15:0] cnt;
  logic        redirect_take;

  assign redirect_take = (state != HALT) && !flag_halt && PcSel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (redirect_take && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign redirect_cnt = cnt;
`else
  assign redirect_cnt = '0;
`endif

endmodule
